// File: rtl/axi_mem_read_slave_pkg.sv
// rtl/axi_mem_read_slave_pkg.sv - shared AXI burst/response types and width constants
package axi_mem_read_slave_pkg;

    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_RESP_WIDTH  = 2;

    typedef enum logic [AXI_BURST_WIDTH-1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mem_read_slave_addr_gen.sv
// rtl/axi_mem_read_slave_addr_gen.sv - combinational beat word address and illegal-burst flag
module axi_burst_addr_gen
    import axi_mem_read_slave_pkg::*;
#(
    parameter int WADDR_WIDTH   = 30,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [WADDR_WIDTH-1:0]   i_start_waddr,
    input  logic [AXI_LEN_WIDTH-1:0] i_len,
    input  axi_burst_t               i_burst,
    input  logic [AXI_LEN_WIDTH-1:0] i_beat,
    output logic [WADDR_WIDTH-1:0]   o_beat_waddr,
    output logic                     o_illegal
);

    // N-1 doubles as the wrap mask; only meaningful for legal power-of-two wraps
    logic [WADDR_WIDTH-1:0] w_mask;
    logic [WADDR_WIDTH-1:0] w_incr;
    logic                   w_wrap_len_ok;

    assign w_mask        = WADDR_WIDTH'(i_len);
    assign w_incr        = i_start_waddr + WADDR_WIDTH'(i_beat);
    assign w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);

    // Select the beat address according to the burst type
    always_comb begin
        o_beat_waddr = i_start_waddr;
        case (i_burst)
            AXI_BURST_FIXED: o_beat_waddr = i_start_waddr;
            AXI_BURST_INCR:  o_beat_waddr = w_incr;
            AXI_BURST_WRAP:  o_beat_waddr = (i_start_waddr & ~w_mask) | (w_incr & w_mask);
            default:         o_beat_waddr = i_start_waddr;
        endcase
    end

    // Reserved type, odd wrap length or an over-long burst are all answered with SLVERR
    always_comb begin
        o_illegal = 1'b0;
        if (i_burst == AXI_BURST_RSVD)
            o_illegal = 1'b1;
        if (i_burst == AXI_BURST_WRAP && !w_wrap_len_ok)
            o_illegal = 1'b1;
        if ((int'(i_len) + 1) > MAX_BURST_LEN)
            o_illegal = 1'b1;
    end

endmodule

// File: rtl/axi_mem_read_slave.sv
// rtl/axi_mem_read_slave.sv - AXI4 read-only memory slave with programmable latency (option: AXI_MEM_RANGE_CHECK_EN)
module axi_mem_read_slave
    import axi_mem_read_slave_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int MEM_WORDS     = 8192,
    parameter int LATENCY       = 10,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [AXI_LEN_WIDTH-1:0]  arlen,
    input  logic [AXI_BURST_WIDTH-1:0] arburst,
    input  logic [ID_WIDTH-1:0]       arid,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [AXI_RESP_WIDTH-1:0] rresp,
    output logic                      rlast,
    output logic [ID_WIDTH-1:0]       rid
);

    localparam int BYTE_SHIFT  = $clog2(DATA_WIDTH / 8);
    localparam int WADDR_WIDTH = ADDR_WIDTH - BYTE_SHIFT;
    localparam int IDX_WIDTH   = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [1:0]               r_state;
    logic [7:0]               r_cnt;
    logic [AXI_LEN_WIDTH-1:0] r_beat;
    logic [AXI_LEN_WIDTH-1:0] r_len;
    logic [WADDR_WIDTH-1:0]   r_waddr;
    axi_burst_t               r_burst;
    logic [ID_WIDTH-1:0]      r_id;

    logic [WADDR_WIDTH-1:0]   w_beat_waddr;
    logic                     w_err;
    logic                     w_in_range;
    logic [IDX_WIDTH-1:0]     w_idx;
    logic [DATA_WIDTH-1:0]    w_mem [MEM_WORDS];
    logic                     w_unused_bits;

    // Backing store: word i holds i, fixed at elaboration
    for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_mem
        assign w_mem[gi] = DATA_WIDTH'(gi);
    end

    axi_burst_addr_gen #(
        .WADDR_WIDTH   (WADDR_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_addr_gen (
        .i_start_waddr (r_waddr),
        .i_len         (r_len),
        .i_burst       (r_burst),
        .i_beat        (r_beat),
        .o_beat_waddr  (w_beat_waddr),
        .o_illegal     (w_err)
    );

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign w_in_range = (w_beat_waddr >> IDX_WIDTH) == '0;
`else
    assign w_in_range = 1'b1;
`endif

    assign w_idx         = w_beat_waddr[IDX_WIDTH-1:0];
    assign w_unused_bits = ^{araddr[BYTE_SHIFT-1:0], w_beat_waddr};

    // Capture AR, count down the access latency, then step through the beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_len   <= '0;
            r_waddr <= '0;
            r_burst <= AXI_BURST_FIXED;
            r_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arvalid) begin
                        r_waddr <= araddr[ADDR_WIDTH-1:BYTE_SHIFT];
                        r_len   <= arlen;
                        r_burst <= axi_burst_t'(arburst);
                        r_id    <= arid;
                        r_beat  <= '0;
                        r_cnt   <= 8'(LATENCY - 1);
                        r_state <= (LATENCY == 1) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Leaving on a count of 1 puts the first beat LATENCY-1 edges after capture
                    if (r_cnt <= 8'd1) begin
                        r_cnt   <= '0;
                        r_state <= S_BURST;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_BURST: begin
                    if (rready) begin
                        if (r_beat == r_len) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // R channel is derived from held state, so it stays stable while stalled
    always_comb begin
        arready = (r_state == S_IDLE);
        rvalid  = (r_state == S_BURST);
        rlast   = rvalid && (r_beat == r_len);
        rid     = r_id;
        rdata   = '0;
        rresp   = AXI_RESP_OKAY;
        if (rvalid) begin
            if (w_err || !w_in_range) begin
                rresp = AXI_RESP_SLVERR;
            end else begin
                rdata = w_mem[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_read_slave.sv
// tb/tb_axi_mem_read_slave.sv - scoreboard bench for axi_mem_read_slave
module tb_axi_mem_read_slave;
    import axi_mem_read_slave_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] araddr  [2];
    logic [7:0]  arlen   [2];
    logic [1:0]  arburst [2];
    logic [3:0]  arid    [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rlast   [2];
    logic [3:0]  rid     [2];

    int    lat [2] = '{10, 1};
    bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    beat_t exp_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    hs_cnt  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        beat_t cur;
        beat_t prev;
        beat_t e;
        bit    prev_stall = 1'b0;

        axi_mem_read_slave #(
            .MEM_WORDS (g == 0 ? 8192 : 16),
            .LATENCY   (g == 0 ? 10 : 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .araddr  (araddr[g]),
            .arlen   (arlen[g]),
            .arburst (arburst[g]),
            .arid    (arid[g]),
            .rvalid  (rvalid[g]),
            .rready  (rready[g]),
            .rdata   (rdata[g]),
            .rresp   (rresp[g]),
            .rlast   (rlast[g]),
            .rid     (rid[g])
        );

        initial begin : monitor
            forever begin
                @(negedge clk);
                cur = {rdata[g], rresp[g], rlast[g], rid[g]};
                if (prev_stall) begin
                    n_tests++;
                    if (!rvalid[g] || cur != prev) begin
                        n_fail++;
                        $display("FAIL stall_hold dut%0d: got v=%0b %h want v=1 %h", g, rvalid[g], cur, prev);
                    end
                end
                if (rvalid[g] && rready[g]) begin
                    hs_cnt++;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat dut%0d: got %h want none", g, cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur != e) begin
                            n_fail++;
                            $display("FAIL beat dut%0d: got data=%h resp=%0d last=%0b id=%0d want data=%h resp=%0d last=%0b id=%0d",
                                     g, cur.data, cur.resp, cur.last, cur.id, e.data, e.resp, e.last, e.id);
                        end
                    end
                end
                prev_stall = rvalid[g] && !rready[g] && !rst[g];
                prev       = cur;
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic [1:0] resp, input logic last, input logic [3:0] id);
        beat_t b;
        b = {data, resp, last, id};
        exp_q.push_back(b);
    endtask

    // Issue one AR and return once the first beat is presented
    task automatic issue_ar(input int d, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] bt, input logic [3:0] id);
        int cnt;
        arvalid[d] = 1'b1;
        araddr[d]  = addr;
        arlen[d]   = len;
        arburst[d] = bt;
        arid[d]    = id;
        cnt = 0;
        while (!arready[d] && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        @(posedge clk); #1;
        arvalid[d] = 1'b0;
        check("arready_busy", longint'(arready[d]), 0);
        cnt = 0;
        while (!rvalid[d] && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("first_rvalid_latency", cnt, lat[d] - 1);
    endtask

    task automatic burst(input int d, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] bt, input logic [3:0] id, input bit stall);
        int cyc;
        issue_ar(d, addr, len, bt, id);
        cyc = 0;
        while (!arready[d] && cyc < 1000) begin
            rready[d] = stall ? pat[cyc % 4] : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        rready[d] = 1'b1;
        check("burst_done_in_budget", longint'(cyc < 1000), 1);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; arvalid[d] = 1'b0; araddr[d] = '0; arlen[d] = '0;
            arburst[d] = '0; arid[d] = '0; rready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", longint'(arready[0]), 1);
        check("rst_rvalid",  longint'(rvalid[0]), 0);
        check("rst_rlast",   longint'(rlast[0]), 0);
        check("rst_rresp",   longint'(rresp[0]), 0);
        check("rst_rdata",   longint'(rdata[0]), 0);
        check("rst_rid",     longint'(rid[0]), 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk); #1;

        // INCR 0x40 len 7: words 0x10..0x17
        for (int i = 0; i < 8; i++) push(32'h10 + i, 2'b00, i == 7, 4'd3);
        burst(0, 32'h40, 8'd7, 2'b01, 4'd3, 1'b0);

        // WRAP 0x38 len 3: 0x0E 0x0F 0x0C 0x0D
        push(32'h0E, 2'b00, 1'b0, 4'd5);
        push(32'h0F, 2'b00, 1'b0, 4'd5);
        push(32'h0C, 2'b00, 1'b0, 4'd5);
        push(32'h0D, 2'b00, 1'b1, 4'd5);
        burst(0, 32'h38, 8'd3, 2'b10, 4'd5, 1'b0);

        // FIXED 0x20 len 3 with backpressure: four beats of 0x08
        for (int i = 0; i < 4; i++) push(32'h08, 2'b00, i == 3, 4'd2);
        hs_cnt = 0;
        burst(0, 32'h20, 8'd3, 2'b00, 4'd2, 1'b1);
        check("fixed_handshakes", hs_cnt, 4);

        // Reserved burst type: three SLVERR beats
        for (int i = 0; i < 3; i++) push(32'h0, 2'b10, i == 2, 4'd7);
        burst(0, 32'h40, 8'd2, 2'b11, 4'd7, 1'b0);

        // WRAP with N=3 is illegal
        for (int i = 0; i < 3; i++) push(32'h0, 2'b10, i == 2, 4'd1);
        burst(0, 32'h10, 8'd2, 2'b10, 4'd1, 1'b0);

        // N=16 is the largest legal burst
        for (int i = 0; i < 16; i++) push(i, 2'b00, i == 15, 4'd9);
        burst(0, 32'h0, 8'd15, 2'b01, 4'd9, 1'b0);

        // N=17 exceeds the limit: 17 SLVERR beats
        for (int i = 0; i < 17; i++) push(32'h0, 2'b10, i == 16, 4'd4);
        burst(0, 32'h0, 8'd16, 2'b01, 4'd4, 1'b0);

        // Reset on the second beat of an 8-beat burst
        push(32'h10, 2'b00, 1'b0, 4'd1);
        push(32'h11, 2'b00, 1'b0, 4'd1);
        issue_ar(0, 32'h40, 8'd7, 2'b01, 4'd1);
        rready[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("abort_rvalid",  longint'(rvalid[0]), 0);
        check("abort_arready", longint'(arready[0]), 1);
        check("abort_rdata",   longint'(rdata[0]), 0);
        check("abort_drained", exp_q.size(), 0);
        push(32'h10, 2'b00, 1'b0, 4'd6);
        push(32'h11, 2'b00, 1'b1, 4'd6);
        burst(0, 32'h40, 8'd1, 2'b01, 4'd6, 1'b0);

        // 16-word memory, LATENCY=1: INCR crossing the top of memory
        push(32'h0E, 2'b00, 1'b0, 4'd6);
        push(32'h0F, 2'b00, 1'b0, 4'd6);
`ifdef AXI_MEM_RANGE_CHECK_EN
        push(32'h00, 2'b10, 1'b0, 4'd6);
        push(32'h00, 2'b10, 1'b1, 4'd6);
`else
        push(32'h00, 2'b00, 1'b0, 4'd6);
        push(32'h01, 2'b00, 1'b1, 4'd6);
`endif
        burst(1, 32'h38, 8'd3, 2'b01, 4'd6, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
